wb_result_stage: RTL and testbench
==================================

Name: wb_result_stage

Overview:
Parametrised writeback-select stage for the RISC-V core. It sits between MEM and the register file.
- Selects the destination value for every opcode class: LUI, AUIPC, JAL/JALR link, load, ALU.
- Aligns and sign/zero-extends load data.
- Registers the result behind a 2-entry valid/ready skid buffer so memory stalls and regfile arbitration do not break the pipeline.
- Exposes the head entry as a forwarding source.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ILEN_PC_INC, 4, link increment added to pc for JAL/JALR.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
opcode  in  7  full RISC-V opcode field
funct3  in  3  load width/sign selector
rd  in  5  destination register
pc  in  XLEN  instruction PC
imm  in  XLEN  decoded, already-positioned immediate
alu_result  in  XLEN  ALU output
mem_rdata  in  XLEN  raw memory read word
addr_lo  in  $clog2(XLEN/8)  low bits of the load address
wb_valid  out  1  head entry valid
wb_ready  in  1  regfile port accepts the head entry
wb_we  out  1  head entry writes the regfile
wb_rd  out  5  head destination
wb_data  out  XLEN  head write data
wb_misalign  out  1  head load was misaligned (no write)
wb_illegal  out  1  head load funct3 illegal for XLEN (no write)
fwd_valid  out  1  equals wb_valid & wb_we
fwd_rd  out  5  equals wb_rd
fwd_data  out  XLEN  equals wb_data

Behaviour:
- Reset (async, rst_n=0):
  - Both entries invalid.
  - wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_misalign=0, wb_illegal=0.
  - in_ready=1 from the first cycle after deassertion.
  - Reset mid-operation discards all held entries immediately.
- Accept on in_valid&in_ready. Pop on wb_valid&wb_ready.
- in_ready is a registered signal: in_ready = !(skid entry occupied).
- Latency:
  - Output is empty: the entry appears on wb_* the next cycle.
  - wb_ready held high: throughput is 1/cycle.
- Skid behaviour:
  - Head occupied and not popping: a new accept goes to the skid entry.
  - Head pops: skid moves to head, or the new accept moves to head if skid is empty.
  - Order is strictly FIFO.
  - Pop and accept in the same cycle with skid full cannot happen, because in_ready=0.
- Select, computed combinationally at accept, stored registered (all arithmetic mod 2^XLEN, wrap allowed):
  - 0110111 LUI: imm.
  - 0010111 AUIPC: pc+imm.
  - 1101111 JAL, 1100111 JALR: pc+ILEN_PC_INC.
  - 0000011 LOAD: load_align result.
  - 0110011 OP, 0010011 OP-IMM, and, when XLEN=64, 0111011/0011011: alu_result.
  - Any other opcode (STORE, BRANCH, SYSTEM, FENCE, unknown): wb_we=0, wb_data=0. The entry still flows through.
- rd==0: wb_we=0 and wb_data=0 regardless of opcode.
- Load alignment: shift mem_rdata right by 8*addr_lo, then extend.
  - 000 LB sign / 100 LBU zero (8 bits).
  - 001 LH / 101 LHU (16 bits).
  - 010 LW (sign-extended when XLEN=64).
  - 110 LWU and 011 LD: XLEN=64 only.
  - Misaligned (addr_lo not a multiple of the access size): wb_misalign=1, wb_we=0.
  - Illegal funct3 for XLEN: wb_illegal=1, wb_we=0.
  - The flags go to the trap unit; the stage itself does nothing else on error.
- All wb_* and fwd_* outputs are stable while wb_valid=1 and wb_ready=0.

Decomposition:
- riscv_pkg holds:
  - Opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32).
  - Load funct3 constants.
  - A wb_entry_t struct {we, rd, data, misalign, illegal}.
- Sub-module load_align (combinational, parametrised by XLEN).
- The select logic and the skid buffer stay in wb_result_stage.

Test Plan:
1. XLEN=32, wb_ready=1. LUI rd=5 imm=0x12345000 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x12345000. Then AUIPC pc=0x1000 imm=0x2000 -> wb_data=0x00003000.
2. JAL rd=1 pc=0xFFFFFFFC -> wb_data=0x00000000 (wrap). JALR rd=0 pc=0x100 -> wb_we=0, wb_data=0. STORE -> wb_we=0.
3. Loads with mem_rdata=0x80FF7F00:
   - LB addr_lo=3 -> 0xFFFFFF80; LBU addr_lo=3 -> 0x00000080.
   - LH addr_lo=2 -> 0xFFFF80FF; LH addr_lo=1 -> wb_misalign=1, wb_we=0.
   - LD funct3=011 at XLEN=32 -> wb_illegal=1, wb_we=0.
4. Backpressure: wb_ready=0, push A, B, C back-to-back.
   - A and B accepted; in_ready=0 while C is offered.
   - Raise wb_ready: pops in order A, B, then C is accepted and pops. No loss, no duplication.
   - fwd_* tracks the head throughout.
5. XLEN=64: LWU mem_rdata=0xFFFFFFFF_80000000 addr_lo=4 -> 0x00000000_FFFFFFFF; LW same input -> 0xFFFFFFFF_FFFFFFFF.
6. Two entries held, assert rst_n=0 asynchronously mid-cycle -> wb_valid=0 and wb_we=0 immediately. After release, in_ready=1 and the first new entry emerges with 1-cycle latency.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the writeback stage.
//   - Opcode and load-funct3 encodings.
//   - wb_entry_t, the record held in each skid-buffer slot. Its data field
//     is sized for the widest legal XLEN. Narrower cores zero-fill the
//     upper bits.
package riscv_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic                we;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] data;
        logic                misalign;
        logic                illegal;
    } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data alignment and extension.
//   funct3    : load width/sign selector
//   addr_lo   : byte offset of the load within the memory word
//   mem_rdata : raw memory read word
//   data      : aligned, extended load value (zero on any error)
//   misalign  : offset is not a multiple of the access size
//   illegal   : funct3 does not name a load that exists for this XLEN
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]               funct3,
    input  logic [$clog2(XLEN/8)-1:0] addr_lo,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic [XLEN-1:0]          data,
    output logic                     misalign,
    output logic                     illegal
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] word_s;
    logic [XLEN-1:0] word_z;

    // Bring the addressed byte down to bit 0.
    assign shifted = mem_rdata >> {addr_lo, 3'b000};

    // Word extension only differs from a pass-through on RV64.
    if (XLEN == 64) begin : g_rv64
        assign word_s = {{32{shifted[31]}}, shifted[31:0]};
        assign word_z = {32'b0, shifted[31:0]};
    end else begin : g_rv32
        assign word_s = shifted;
        assign word_z = shifted;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data     = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH: begin
                misalign = addr_lo[0];
                data     = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            F3_LHU: begin
                misalign = addr_lo[0];
                data     = {{(XLEN-16){1'b0}}, shifted[15:0]};
            end
            F3_LW: begin
                misalign = (addr_lo[1:0] != 2'b00);
                data     = word_s;
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    misalign = (addr_lo[1:0] != 2'b00);
                    data     = word_z;
                end else begin
                    illegal = 1'b1;
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    misalign = (addr_lo != '0);
                    data     = shifted;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // A faulting load never carries data toward the register file.
        if (misalign || illegal) begin
            data = '0;
        end
    end

endmodule

// File: rtl/wb_result_stage.sv
// wb_result_stage: writeback-select stage between MEM and the register file.
//   in_valid/in_ready : upstream handshake (in_ready = skid slot free)
//   opcode, funct3, rd, pc, imm, alu_result, mem_rdata, addr_lo : instruction
//                       fields and operands used to pick the result
//   wb_valid/wb_ready : head-entry handshake toward the regfile
//   wb_we, wb_rd, wb_data, wb_misalign, wb_illegal : head entry contents
//   fwd_valid, fwd_rd, fwd_data : head entry as a forwarding source
// The result is chosen at accept time and held in a two-slot (head + skid)
// FIFO so that downstream stalls never combinationally reach upstream.
module wb_result_stage
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ILEN_PC_INC = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic [4:0]                rd,
    input  logic [XLEN-1:0]           pc,
    input  logic [XLEN-1:0]           imm,
    input  logic [XLEN-1:0]           alu_result,
    input  logic [XLEN-1:0]           mem_rdata,
    input  logic [$clog2(XLEN/8)-1:0] addr_lo,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      wb_we,
    output logic [4:0]                wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic                      wb_misalign,
    output logic                      wb_illegal,
    output logic                      fwd_valid,
    output logic [4:0]                fwd_rd,
    output logic [XLEN-1:0]           fwd_data
);

    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;
    logic            ld_illegal;
    wb_entry_t       sel;
    wb_entry_t       head_q;
    wb_entry_t       skid_q;
    logic            head_v;
    logic            skid_v;
    logic            accept;
    logic            pop;
    logic            unused_data;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3    (funct3),
        .addr_lo   (addr_lo),
        .mem_rdata (mem_rdata),
        .data      (ld_data),
        .misalign  (ld_misalign),
        .illegal   (ld_illegal)
    );

    always_comb begin
        sel    = '0;
        sel.rd = rd;
        case (opcode)
            OPC_LUI: begin
                sel.we              = 1'b1;
                sel.data[XLEN-1:0]  = imm;
            end
            OPC_AUIPC: begin
                sel.we              = 1'b1;
                sel.data[XLEN-1:0]  = pc + imm;
            end
            OPC_JAL, OPC_JALR: begin
                sel.we              = 1'b1;
                sel.data[XLEN-1:0]  = pc + XLEN'(ILEN_PC_INC);
            end
            OPC_LOAD: begin
                sel.we              = !(ld_misalign || ld_illegal);
                sel.data[XLEN-1:0]  = ld_data;
                sel.misalign        = ld_misalign;
                sel.illegal         = ld_illegal;
            end
            OPC_OP, OPC_OPIMM: begin
                sel.we              = 1'b1;
                sel.data[XLEN-1:0]  = alu_result;
            end
            OPC_OP32, OPC_OPIMM32: begin
                // Word-sized ALU ops exist only on RV64; elsewhere they write nothing.
                if (XLEN == 64) begin
                    sel.we             = 1'b1;
                    sel.data[XLEN-1:0] = alu_result;
                end
            end
            default: ;
        endcase
        // x0 is hardwired to zero; load fault flags still go to the trap unit.
        if (rd == 5'd0) begin
            sel.we   = 1'b0;
            sel.data = '0;
        end
    end

    assign in_ready = !skid_v;
    assign accept   = in_valid && in_ready;
    assign pop      = head_v && wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both slots are reset, not just their valid bits, because the head
            // contents drive wb_* directly and must read as zero out of reset.
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every slot update sees pre-edge values.
            if (pop) begin
                if (skid_v) begin
                    // in_ready was low, so no accept can coincide with this move.
                    head_q <= skid_q;
                    skid_v <= 1'b0;
                end else if (accept) begin
                    head_q <= sel;
                end else begin
                    head_v <= 1'b0;
                end
            end else if (accept) begin
                if (head_v) begin
                    skid_q <= sel;
                    skid_v <= 1'b1;
                end else begin
                    head_q <= sel;
                    head_v <= 1'b1;
                end
            end
        end
    end

    assign wb_valid    = head_v;
    assign wb_we       = head_v && head_q.we;
    assign wb_rd       = head_q.rd;
    assign wb_data     = head_q.data[XLEN-1:0];
    assign wb_misalign = head_v && head_q.misalign;
    assign wb_illegal  = head_v && head_q.illegal;

    assign fwd_valid = wb_valid && wb_we;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;

    // Upper data bits are always zero when XLEN is below the struct width.
    assign unused_data = ^head_q.data;

endmodule

// File: tb/tb_wb_result_stage.sv
// tb_wb_result_stage: directed checks of wb_result_stage at XLEN=32 (dut_a)
// and XLEN=64 (dut_b). Inputs change 1 ns after a rising edge and outputs
// are checked at that same point, well away from the next edge.
module tb_wb_result_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // XLEN=32 instance signals
    logic        a_in_valid, a_in_ready, a_wb_ready;
    logic [6:0]  a_opcode;
    logic [2:0]  a_funct3;
    logic [4:0]  a_rd;
    logic [31:0] a_pc, a_imm, a_alu, a_mem;
    logic [1:0]  a_addr_lo;
    logic        a_wb_valid, a_wb_we, a_wb_misalign, a_wb_illegal, a_fwd_valid;
    logic [4:0]  a_wb_rd, a_fwd_rd;
    logic [31:0] a_wb_data, a_fwd_data;

    // XLEN=64 instance signals
    logic        b_in_valid, b_in_ready, b_wb_ready;
    logic [6:0]  b_opcode;
    logic [2:0]  b_funct3;
    logic [4:0]  b_rd;
    logic [63:0] b_pc, b_imm, b_alu, b_mem;
    logic [2:0]  b_addr_lo;
    logic        b_wb_valid, b_wb_we, b_wb_misalign, b_wb_illegal, b_fwd_valid;
    logic [4:0]  b_wb_rd, b_fwd_rd;
    logic [63:0] b_wb_data, b_fwd_data;

    int n_tests = 0;
    int n_fail  = 0;

    wb_result_stage #(.XLEN(32), .ILEN_PC_INC(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .opcode(a_opcode), .funct3(a_funct3), .rd(a_rd),
        .pc(a_pc), .imm(a_imm), .alu_result(a_alu),
        .mem_rdata(a_mem), .addr_lo(a_addr_lo),
        .wb_valid(a_wb_valid), .wb_ready(a_wb_ready), .wb_we(a_wb_we),
        .wb_rd(a_wb_rd), .wb_data(a_wb_data),
        .wb_misalign(a_wb_misalign), .wb_illegal(a_wb_illegal),
        .fwd_valid(a_fwd_valid), .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data)
    );

    wb_result_stage #(.XLEN(64), .ILEN_PC_INC(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opcode(b_opcode), .funct3(b_funct3), .rd(b_rd),
        .pc(b_pc), .imm(b_imm), .alu_result(b_alu),
        .mem_rdata(b_mem), .addr_lo(b_addr_lo),
        .wb_valid(b_wb_valid), .wb_ready(b_wb_ready), .wb_we(b_wb_we),
        .wb_rd(b_wb_rd), .wb_data(b_wb_data),
        .wb_misalign(b_wb_misalign), .wb_illegal(b_wb_illegal),
        .fwd_valid(b_fwd_valid), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                           input logic [31:0] p, input logic [31:0] im, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [1:0] al);
        a_in_valid = 1'b1; a_opcode = op; a_funct3 = f3; a_rd = r;
        a_pc = p; a_imm = im; a_alu = alu; a_mem = mem; a_addr_lo = al;
    endtask

    task automatic drive_b(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                           input logic [63:0] alu, input logic [63:0] mem, input logic [2:0] al);
        b_in_valid = 1'b1; b_opcode = op; b_funct3 = f3; b_rd = r;
        b_pc = '0; b_imm = '0; b_alu = alu; b_mem = mem; b_addr_lo = al;
    endtask

    initial begin
        rst_n = 1'b0;
        a_wb_ready = 1'b1; b_wb_ready = 1'b1;
        drive_a(7'b0, 3'b0, 5'd0, '0, '0, '0, '0, '0); a_in_valid = 1'b0;
        drive_b(7'b0, 3'b0, 5'd0, '0, '0, '0);          b_in_valid = 1'b0;

        // Reset state
        #1;
        check("rst_wb_valid", a_wb_valid, 0);
        check("rst_wb_we", a_wb_we, 0);
        check("rst_wb_rd", a_wb_rd, 0);
        check("rst_wb_data", a_wb_data, 0);
        check("rst_flags", {a_wb_misalign, a_wb_illegal}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", a_in_ready, 1);
        check("rst_wb_valid_after", a_wb_valid, 0);

        // 1. LUI then AUIPC, wb_ready high
        drive_a(OPC_LUI, 3'b0, 5'd5, '0, 32'h12345000, '0, '0, '0);
        tick();
        check("lui_valid", a_wb_valid, 1);
        check("lui_we", a_wb_we, 1);
        check("lui_rd", a_wb_rd, 5);
        check("lui_data", a_wb_data, 32'h12345000);
        drive_a(OPC_AUIPC, 3'b0, 5'd6, 32'h1000, 32'h2000, '0, '0, '0);
        tick();
        check("auipc_data", a_wb_data, 32'h00003000);
        check("auipc_rd", a_wb_rd, 6);

        // 2. Link wrap, rd=0, store, plus ALU paths
        drive_a(OPC_JAL, 3'b0, 5'd1, 32'hFFFFFFFC, '0, '0, '0, '0);
        tick();
        check("jal_we", a_wb_we, 1);
        check("jal_wrap_data", a_wb_data, 32'h0);
        drive_a(OPC_JALR, 3'b0, 5'd0, 32'h100, '0, '0, '0, '0);
        tick();
        check("jalr_x0_valid", a_wb_valid, 1);
        check("jalr_x0_we", a_wb_we, 0);
        check("jalr_x0_data", a_wb_data, 0);
        drive_a(7'b0100011, 3'b010, 5'd3, 32'h40, 32'h8, 32'h48, '0, '0);
        tick();
        check("store_valid", a_wb_valid, 1);
        check("store_we", a_wb_we, 0);
        check("store_data", a_wb_data, 0);
        drive_a(OPC_OP, 3'b0, 5'd7, '0, '0, 32'hDEADBEEF, '0, '0);
        tick();
        check("op_data", a_wb_data, 32'hDEADBEEF);
        check("op_fwd_valid", a_fwd_valid, 1);
        drive_a(OPC_OP32, 3'b0, 5'd8, '0, '0, 32'h11, '0, '0);
        tick();
        check("op32_rv32_we", a_wb_we, 0);

        // 3. Loads from 0x80FF7F00
        drive_a(OPC_LOAD, F3_LB, 5'd9, '0, '0, '0, 32'h80FF7F00, 2'd3);
        tick();
        check("lb_data", a_wb_data, 32'hFFFFFF80);
        check("lb_we", a_wb_we, 1);
        drive_a(OPC_LOAD, F3_LBU, 5'd9, '0, '0, '0, 32'h80FF7F00, 2'd3);
        tick();
        check("lbu_data", a_wb_data, 32'h00000080);
        drive_a(OPC_LOAD, F3_LH, 5'd9, '0, '0, '0, 32'h80FF7F00, 2'd2);
        tick();
        check("lh_data", a_wb_data, 32'hFFFF80FF);
        check("lh_misalign_clear", a_wb_misalign, 0);
        drive_a(OPC_LOAD, F3_LH, 5'd9, '0, '0, '0, 32'h80FF7F00, 2'd1);
        tick();
        check("lh_mis_flag", a_wb_misalign, 1);
        check("lh_mis_we", a_wb_we, 0);
        drive_a(OPC_LOAD, F3_LW, 5'd9, '0, '0, '0, 32'h80FF7F00, 2'd0);
        tick();
        check("lw_data", a_wb_data, 32'h80FF7F00);
        drive_a(OPC_LOAD, F3_LD, 5'd9, '0, '0, '0, 32'h80FF7F00, 2'd0);
        tick();
        check("ld_rv32_illegal", a_wb_illegal, 1);
        check("ld_rv32_we", a_wb_we, 0);

        // 4. Backpressure and FIFO order
        a_in_valid = 1'b0;
        tick();
        check("drain_valid", a_wb_valid, 0);
        a_wb_ready = 1'b0;
        drive_a(OPC_OP, 3'b0, 5'd10, '0, '0, 32'hAAAA0001, '0, '0);
        tick();
        check("bp_a_rd", a_wb_rd, 10);
        check("bp_a_in_ready", a_in_ready, 1);
        drive_a(OPC_OP, 3'b0, 5'd11, '0, '0, 32'hBBBB0002, '0, '0);
        tick();
        check("bp_b_head_rd", a_wb_rd, 10);
        check("bp_b_in_ready", a_in_ready, 0);
        check("bp_fwd_rd", a_fwd_rd, 10);
        check("bp_fwd_data", a_fwd_data, 32'hAAAA0001);
        drive_a(OPC_OP, 3'b0, 5'd12, '0, '0, 32'hCCCC0003, '0, '0);
        tick();
        check("bp_c_stall_rd", a_wb_rd, 10);
        check("bp_c_stall_data", a_wb_data, 32'hAAAA0001);
        check("bp_c_in_ready", a_in_ready, 0);
        a_wb_ready = 1'b1;
        tick();
        check("pop_b_rd", a_wb_rd, 11);
        check("pop_b_data", a_fwd_data, 32'hBBBB0002);
        check("pop_b_in_ready", a_in_ready, 1);
        tick();
        check("pop_c_rd", a_fwd_rd, 12);
        check("pop_c_data", a_wb_data, 32'hCCCC0003);
        a_in_valid = 1'b0;
        tick();
        check("pop_empty", a_wb_valid, 0);
        check("pop_empty_fwd", a_fwd_valid, 0);

        // 5. XLEN=64 loads and word ops
        drive_b(OPC_LOAD, F3_LWU, 5'd6, '0, 64'hFFFFFFFF_80000000, 3'd4);
        tick();
        check("rv64_lwu", b_wb_data, 64'h00000000_FFFFFFFF);
        drive_b(OPC_LOAD, F3_LW, 5'd6, '0, 64'hFFFFFFFF_80000000, 3'd4);
        tick();
        check("rv64_lw", b_wb_data, 64'hFFFFFFFF_FFFFFFFF);
        drive_b(OPC_LOAD, F3_LD, 5'd6, '0, 64'h01234567_89ABCDEF, 3'd0);
        tick();
        check("rv64_ld", b_wb_data, 64'h01234567_89ABCDEF);
        check("rv64_ld_legal", b_wb_illegal, 0);
        drive_b(OPC_LOAD, F3_LD, 5'd6, '0, 64'h01234567_89ABCDEF, 3'd4);
        tick();
        check("rv64_ld_misalign", b_wb_misalign, 1);
        check("rv64_ld_mis_we", b_wb_we, 0);
        drive_b(OPC_OP32, 3'b0, 5'd4, 64'h5, '0, 3'd0);
        tick();
        check("rv64_op32", b_wb_data, 64'h5);
        check("rv64_op32_we", b_wb_we, 1);
        b_in_valid = 1'b0;

        // 6. Asynchronous reset with two entries held
        a_wb_ready = 1'b0;
        drive_a(OPC_OP, 3'b0, 5'd13, '0, '0, 32'hD0D0D0D0, '0, '0);
        tick();
        drive_a(OPC_OP, 3'b0, 5'd14, '0, '0, 32'hE0E0E0E0, '0, '0);
        tick();
        check("full_in_ready", a_in_ready, 0);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_wb_valid", a_wb_valid, 0);
        check("arst_wb_we", a_wb_we, 0);
        check("arst_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        a_wb_ready = 1'b1;
        drive_a(OPC_OP, 3'b0, 5'd15, '0, '0, 32'hF00DF00D, '0, '0);
        tick();
        check("post_rst_valid", a_wb_valid, 1);
        check("post_rst_rd", a_wb_rd, 15);
        check("post_rst_data", a_wb_data, 32'hF00DF00D);
        a_in_valid = 1'b0;
        tick();
        check("post_rst_drain", a_wb_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
